// File: rtl/line_buffer_ctrl_pkg.sv
// Shared definitions for the line-buffer controller: FSM encoding, default
// geometry and the address-width helper.
package line_buffer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_STREAM = 2'd2
  } lb_state_e;

  // Address width for a given edge; floor of 1 bit keeps tiny images legal.
  function automatic int lb_log2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_FILTER_SIZE = 3;
  localparam int DEF_IMAGE_SIZE  = 28;
  localparam int DEF_ADDR_W      = lb_log2(DEF_IMAGE_SIZE);

endpackage

// File: rtl/line_buffer_ctrl_wrap_counter.sv
// Modulo-MOD counter with enable, synchronous clear (clear wins) and a
// combinational flag marking the terminal count.
module wrap_counter #(
  parameter int MOD = 2,
  parameter int W   = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_o  = cnt_q;
  assign wrap_o = (cnt_q == LAST);

  // Next count: clear, else step and wrap at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = wrap_o ? '0 : cnt_q + W'(1);
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Line-buffer controller: tracks pixel position in a square frame, drives the
// external line-buffer RAM addresses/clock enable and flags complete windows.
// Optional feature: define LINE_BUFFER_CTRL_LAST_CHECK_EN to enable the sticky
// in_last consistency flag on err; otherwise err is tied low.
module line_buffer_ctrl
  import line_buffer_ctrl_pkg::*;
#(
  parameter  int FILTER_SIZE = DEF_FILTER_SIZE,
  parameter  int IMAGE_SIZE  = DEF_IMAGE_SIZE,
  localparam int DEPTH       = IMAGE_SIZE - (FILTER_SIZE - 1),
  localparam int AW          = lb_log2(IMAGE_SIZE)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          lb_clk_en,
  output logic [AW-1:0] lb_wr_addr,
  output logic [AW-1:0] lb_rd_addr,
  output logic          frame_done,
  output logic          err
);

  localparam logic [AW-1:0] WIN_START     = AW'(FILTER_SIZE - 1);
  localparam logic [AW-1:0] FILL_LAST_ROW = AW'(FILTER_SIZE - 2);

  logic [AW-1:0] col, row, ptr;
  logic          col_wrap, row_wrap, ptr_wrap;
  logic          accept, frame_end, win_pos, cnt_clr;
  logic          frame_done_q;
  lb_state_e     state_q, state_d;

  // STREAM is exactly the rows at or beyond FILTER_SIZE-1, so the row half of
  // the window test comes from the state rather than a second comparator.
  assign frame_end = col_wrap && row_wrap;
  assign win_pos   = (state_q == ST_STREAM) && (col >= WIN_START);

  // Handshake is fully combinational: the live pixel completes the window.
  assign in_ready  = rst_n && (!win_pos || out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = in_valid && win_pos && !flush;
  assign lb_clk_en = accept;

  // Frame end also clears ptr, since IMAGE_SIZE^2 need not be a DEPTH multiple.
  assign cnt_clr = flush || (accept && frame_end);

  wrap_counter #(.MOD(IMAGE_SIZE), .W(AW)) u_col (
    .clk_i (clk), .rst_ni (rst_n), .en_i (accept), .clr_i (cnt_clr),
    .cnt_o (col), .wrap_o (col_wrap)
  );

  wrap_counter #(.MOD(IMAGE_SIZE), .W(AW)) u_row (
    .clk_i (clk), .rst_ni (rst_n), .en_i (accept && col_wrap), .clr_i (cnt_clr),
    .cnt_o (row), .wrap_o (row_wrap)
  );

  wrap_counter #(.MOD(DEPTH), .W(AW)) u_ptr (
    .clk_i (clk), .rst_ni (rst_n), .en_i (accept), .clr_i (cnt_clr),
    .cnt_o (ptr), .wrap_o (ptr_wrap)
  );

  // Read one ahead of write to hide the RAM's one-cycle read latency.
  assign lb_wr_addr = ptr;
  assign lb_rd_addr = ptr_wrap ? '0 : ptr + AW'(1);

  // Next state: fill rows, stream windows, back to idle at frame end or flush.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (accept) state_d = ST_FILL;
      ST_FILL:   if (accept && col_wrap && (row == FILL_LAST_ROW)) state_d = ST_STREAM;
      ST_STREAM: if (accept && frame_end) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // One-cycle pulse after the final pixel; accept already excludes flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done_q <= 1'b0;
    else        frame_done_q <= accept && frame_end;
  end

  assign frame_done = frame_done_q;

`ifdef LINE_BUFFER_CTRL_LAST_CHECK_EN
  logic err_q;

  // Sticky flag: in_last must mark exactly the final pixel; only reset clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                               err_q <= 1'b0;
    else if (accept && (in_last != frame_end)) err_q <= 1'b1;
  end

  assign err = err_q;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Directed bench for line_buffer_ctrl at FILTER_SIZE=3, IMAGE_SIZE=8 (DEPTH=6).
module tb_line_buffer_ctrl;

  localparam int FS  = 3;
  localparam int IMG = 8;
  localparam int DEP = IMG - (FS - 1);
  localparam int NPX = IMG * IMG;
`ifdef LINE_BUFFER_CTRL_LAST_CHECK_EN
  localparam bit LAST_CHK = 1'b1;
`else
  localparam bit LAST_CHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_last, out_ready;
  logic       in_ready, out_valid, lb_clk_en, frame_done, err;
  logic [2:0] lb_wr_addr, lb_rd_addr;

  int n_tests = 0, n_fail = 0;
  int mk, mptr;
  logic exp_fd, exp_err;
  int mis_hs, mis_addr, mis_fd, mis_err;
  int n_acc, n_win, first_win, n_done;

  always #5 clk = ~clk;

  line_buffer_ctrl #(.FILTER_SIZE(FS), .IMAGE_SIZE(IMG)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .lb_clk_en(lb_clk_en), .lb_wr_addr(lb_wr_addr), .lb_rd_addr(lb_rd_addr),
    .frame_done(frame_done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One cycle: drive at negedge, compare combinational and registered outputs
  // against the position model, then advance the model for the coming edge.
  task automatic step(input logic v, input logic ordy, input logic fl, input logic last);
    int r, c;
    logic ew, er, ea, eo;
    @(negedge clk);
    in_valid = v; out_ready = ordy; flush = fl; in_last = last;
    #1;
    r  = mk / IMG;
    c  = mk % IMG;
    ew = (r >= FS - 1) && (c >= FS - 1);
    er = !ew || ordy;
    ea = v && er && !fl;
    eo = v && ew && !fl;
    if (in_ready !== er || lb_clk_en !== ea || out_valid !== eo) mis_hs++;
    if (lb_wr_addr !== 3'(mptr) || lb_rd_addr !== 3'((mptr + 1) % DEP)) mis_addr++;
    if (frame_done !== exp_fd) mis_fd++;
    if (err !== exp_err) mis_err++;
    if (lb_clk_en === 1'b1) n_acc++;
    if (out_valid === 1'b1 && out_ready) begin
      n_win++;
      if (first_win == 0) first_win = n_acc;
    end
    if (frame_done === 1'b1) n_done++;
    exp_fd = 1'b0;
    if (fl) begin
      mk = 0; mptr = 0;
    end else if (ea) begin
      if (LAST_CHK && (last != (mk == NPX - 1))) exp_err = 1'b1;
      if (mk == NPX - 1) begin
        mk = 0; mptr = 0; exp_fd = 1'b1;
      end else begin
        mk++; mptr = (mptr + 1) % DEP;
      end
    end
  endtask

  // Stream pixels until `target` accepts; optional downstream stall at
  // row 4 col 3 plus one upstream bubble, optional bad in_last at bad_px.
  task automatic run_px(input int target, input bit stall_en, input int bad_px);
    int st, cyc;
    bit gap;
    logic v, o;
    st = 0; cyc = 0; gap = 1'b0;
    n_acc = 0; n_win = 0; first_win = 0;
    while (n_acc < target && cyc < 400) begin
      v = 1'b1; o = 1'b1;
      if (stall_en && mk == 35 && st < 5) begin o = 1'b0; st++; end
      if (stall_en && mk == 5 && !gap) begin v = 1'b0; gap = 1'b1; end
      step(v, o, 1'b0, (mk == NPX - 1) || (mk == bad_px));
      cyc++;
    end
    if (cyc >= 400) chk("timeout", n_acc, target);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b1;
    mk = 0; mptr = 0; exp_fd = 1'b0; exp_err = 1'b0;
    mis_hs = 0; mis_addr = 0; mis_fd = 0; mis_err = 0; n_done = 0;

    // Reset values with upstream pushing.
    #12;
    chk("rst_in_ready",   in_ready,   0);
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_clk_en",     lb_clk_en,  0);
    chk("rst_wr_addr",    lb_wr_addr, 0);
    chk("rst_rd_addr",    lb_rd_addr, 1);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err",        err,        0);
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;

    // Plain frame.
    run_px(NPX, 1'b0, -1);
    chk("f1_accepts",   n_acc,     64);
    chk("f1_windows",   n_win,     36);
    chk("f1_first_win", first_win, 19);

    // Back-to-back frame with stall and bubble.
    run_px(NPX, 1'b1, -1);
    chk("f2_accepts", n_acc, 64);
    chk("f2_windows", n_win, 36);

    // Flush at row 3 col 5, then a full frame.
    run_px(29, 1'b0, -1);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    run_px(NPX, 1'b0, -1);
    chk("flush_windows",   n_win,     36);
    chk("flush_first_win", first_win, 19);

    // Async reset mid-STREAM.
    run_px(40, 1'b0, -1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready",  in_ready,   0);
    chk("mid_rst_out_valid", out_valid,  0);
    chk("mid_rst_clk_en",    lb_clk_en,  0);
    chk("mid_rst_wr_addr",   lb_wr_addr, 0);
    chk("mid_rst_rd_addr",   lb_rd_addr, 1);
    chk("mid_rst_done",      frame_done, 0);
    mk = 0; mptr = 0; exp_fd = 1'b0;
    @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;
    run_px(NPX, 1'b0, -1);
    chk("post_rst_accepts",  n_acc,     64);
    chk("post_rst_windows",  n_win,     36);
    chk("post_rst_first",    first_win, 19);

    // in_last asserted at pixel 10, then a flush.
    run_px(NPX, 1'b0, 10);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("err_after_flush", err, LAST_CHK);

    chk("done_total",      n_done,   5);
    chk("handshake_cycles", mis_hs,  0);
    chk("addr_cycles",     mis_addr, 0);
    chk("frame_done_cycles", mis_fd, 0);
    chk("err_cycles",      mis_err,  0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
